// File: rtl/camera_pkg.sv
// Shared types and helpers for the camera pixel pipeline crop and encoder setup.
package camera_pkg;

  typedef enum logic [1:0] {
    DECIMATE_1 = 2'd0,
    DECIMATE_2 = 2'd1,
    DECIMATE_4 = 2'd2,
    DECIMATE_8 = 2'd3
  } decimation_e;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    ARMED     = 2'd1,
    ACTIVE    = 2'd2,
    SKIP      = 2'd3
  } crop_state_e;

  localparam int unsigned SIZE_CALC_WIDTH = 32;

  // Output dimension of a window span after 1-in-2^d decimation, rounding up.
  function automatic logic [SIZE_CALC_WIDTH-1:0] crop_size(
    input logic [SIZE_CALC_WIDTH-1:0] span,
    input decimation_e                decimation
  );
    logic [SIZE_CALC_WIDTH-1:0] round_up;
    round_up = (SIZE_CALC_WIDTH'(1) << decimation) - SIZE_CALC_WIDTH'(1);
    return (span + round_up) >> decimation;
  endfunction

endpackage

// File: rtl/crop_position_counter.sv
// Pixel x/y position tracking within a frame; both counters saturate instead of wrapping.
module crop_position_counter #(
  parameter int unsigned COORD_WIDTH = 11
) (
  input  logic                   clock_in,
  input  logic                   reset_in,
  input  logic                   line_valid,
  input  logic                   frame_valid,
  output logic [COORD_WIDTH-1:0] x_pos,
  output logic [COORD_WIDTH-1:0] y_pos
);

  localparam logic [COORD_WIDTH-1:0] COORD_MAX = '1;

  logic line_active;
  logic line_active_q;

  // Line strobes outside a frame do not move the counters.
  assign line_active = line_valid & frame_valid;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      x_pos         <= '0;
      y_pos         <= '0;
      line_active_q <= 1'b0;
    end else begin
      line_active_q <= line_active;

      if (!line_active) begin
        x_pos <= '0;
      end else if (x_pos != COORD_MAX) begin
        x_pos <= x_pos + COORD_WIDTH'(1);
      end

      if (!frame_valid) begin
        y_pos <= '0;
      end else if (line_active_q && !line_active && (y_pos != COORD_MAX)) begin
        y_pos <= y_pos + COORD_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/dynamic_crop.sv
// Runtime crop window with power-of-two decimation; window settings latch once per frame.
module dynamic_crop
  import camera_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 10,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned COORD_WIDTH = 11
) (
  input  logic                           clock_in,
  input  logic                           reset_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  input  logic                           line_valid_in,
  input  logic                           frame_valid_in,
  input  logic [COORD_WIDTH-1:0]         x_start_in,
  input  logic [COORD_WIDTH-1:0]         x_end_in,
  input  logic [COORD_WIDTH-1:0]         y_start_in,
  input  logic [COORD_WIDTH-1:0]         y_end_in,
  input  logic [1:0]                     decimation_in,
  output logic [CHANNELS*DATA_WIDTH-1:0] data_out,
  output logic                           line_valid_out,
  output logic                           frame_valid_out,
  output logic [COORD_WIDTH-1:0]         x_size_out,
  output logic [COORD_WIDTH-1:0]         y_size_out,
  output logic                           frame_done_out,
  output logic                           window_error_out
);

  localparam int unsigned PIXEL_WIDTH = CHANNELS * DATA_WIDTH;
  localparam int unsigned SPAN_WIDTH  = COORD_WIDTH + 1;

  crop_state_e state_q;
  crop_state_e state_d;

  logic                   frame_valid_q;
  logic [COORD_WIDTH-1:0] x_start_q;
  logic [COORD_WIDTH-1:0] x_end_q;
  logic [COORD_WIDTH-1:0] y_start_q;
  logic [COORD_WIDTH-1:0] y_end_q;
  decimation_e            decimation_q;

  logic [COORD_WIDTH-1:0] x_pos;
  logic [COORD_WIDTH-1:0] y_pos;

  logic                   frame_rise_c;
  logic                   frame_fall_c;
  logic                   window_empty_c;
  logic                   latch_c;
  logic                   done_c;
  logic                   active_c;
  logic                   keep_c;
  logic [COORD_WIDTH-1:0] x_lo_c;
  logic [COORD_WIDTH-1:0] x_hi_c;
  logic [COORD_WIDTH-1:0] y_lo_c;
  logic [COORD_WIDTH-1:0] y_hi_c;
  logic [1:0]             dec_c;
  logic [COORD_WIDTH-1:0] dec_mask_c;
  logic [COORD_WIDTH-1:0] x_off_c;
  logic [COORD_WIDTH-1:0] y_off_c;
  logic [SPAN_WIDTH-1:0]  x_span_c;
  logic [SPAN_WIDTH-1:0]  y_span_c;
  logic [COORD_WIDTH-1:0] x_size_c;
  logic [COORD_WIDTH-1:0] y_size_c;

  crop_position_counter #(
    .COORD_WIDTH (COORD_WIDTH)
  ) u_position (
    .clock_in    (clock_in),
    .reset_in    (reset_in),
    .line_valid  (line_valid_in),
    .frame_valid (frame_valid_in),
    .x_pos       (x_pos),
    .y_pos       (y_pos)
  );

  assign frame_rise_c   = frame_valid_in & ~frame_valid_q;
  assign frame_fall_c   = ~frame_valid_in & frame_valid_q;
  assign window_empty_c = (x_end_in <= x_start_in) || (y_end_in <= y_start_in);

  // Frame sequencing: latch on the rising frame edge, report done on the falling edge.
  always_comb begin
    state_d = state_q;
    latch_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      WAIT_IDLE: begin
        if (!frame_valid_in) state_d = ARMED;
      end
      ARMED: begin
        if (frame_rise_c) begin
          latch_c = 1'b1;
          state_d = window_empty_c ? SKIP : ACTIVE;
        end
      end
      ACTIVE: begin
        if (frame_fall_c) begin
          done_c  = 1'b1;
          state_d = ARMED;
        end
      end
      SKIP: begin
        if (frame_fall_c) state_d = ARMED;
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // The latch cycle's own pixel is judged against the window being latched.
  always_comb begin
    x_lo_c     = latch_c ? x_start_in : x_start_q;
    x_hi_c     = latch_c ? x_end_in : x_end_q;
    y_lo_c     = latch_c ? y_start_in : y_start_q;
    y_hi_c     = latch_c ? y_end_in : y_end_q;
    dec_c      = latch_c ? decimation_in : decimation_q;
    active_c   = latch_c ? ~window_empty_c : (state_q == ACTIVE);
    dec_mask_c = COORD_WIDTH'((32'd1 << dec_c) - 32'd1);
    x_off_c    = x_pos - x_lo_c;
    y_off_c    = y_pos - y_lo_c;
    keep_c     = active_c && line_valid_in && frame_valid_in &&
                 (x_pos >= x_lo_c) && (x_pos < x_hi_c) &&
                 (y_pos >= y_lo_c) && (y_pos < y_hi_c) &&
                 ((x_off_c & dec_mask_c) == '0) &&
                 ((y_off_c & dec_mask_c) == '0);
    x_span_c   = SPAN_WIDTH'(x_end_in) - SPAN_WIDTH'(x_start_in);
    y_span_c   = SPAN_WIDTH'(y_end_in) - SPAN_WIDTH'(y_start_in);
    x_size_c   = COORD_WIDTH'(crop_size(SIZE_CALC_WIDTH'(x_span_c), decimation_e'(decimation_in)));
    y_size_c   = COORD_WIDTH'(crop_size(SIZE_CALC_WIDTH'(y_span_c), decimation_e'(decimation_in)));
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q <= WAIT_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Shadow window and registered outputs.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      frame_valid_q    <= 1'b0;
      x_start_q        <= '0;
      x_end_q          <= '0;
      y_start_q        <= '0;
      y_end_q          <= '0;
      decimation_q     <= DECIMATE_1;
      data_out         <= '0;
      line_valid_out   <= 1'b0;
      frame_valid_out  <= 1'b0;
      x_size_out       <= '0;
      y_size_out       <= '0;
      frame_done_out   <= 1'b0;
      window_error_out <= 1'b0;
    end else begin
      frame_valid_q <= frame_valid_in;
      if (latch_c) begin
        x_start_q        <= x_start_in;
        x_end_q          <= x_end_in;
        y_start_q        <= y_start_in;
        y_end_q          <= y_end_in;
        decimation_q     <= decimation_e'(decimation_in);
        x_size_out       <= x_size_c;
        y_size_out       <= y_size_c;
        window_error_out <= window_empty_c;
      end
      data_out        <= keep_c ? data_in : PIXEL_WIDTH'(0);
      line_valid_out  <= keep_c;
      frame_valid_out <= (state_d == ACTIVE);
      frame_done_out  <= done_c;
    end
  end

endmodule

// File: tb/tb_dynamic_crop.sv
// Scoreboard bench for dynamic_crop: directed frames, a monitor pops expected pixels and frame sizes.
module tb_dynamic_crop;

  localparam int unsigned PW = 30;

  logic          clk;
  logic          rst;
  logic [PW-1:0] data;
  logic          lv;
  logic          fv;
  logic [10:0]   x_start, x_end, y_start, y_end;
  logic [1:0]    dec;
  logic [PW-1:0] dout;
  logic          lvo, fvo, fdo, werr;
  logic [10:0]   xs, ys;

  logic          sat_en;
  logic          fv_b;
  logic [3:0]    x_start_b, x_end_b, y_start_b, y_end_b;
  logic [PW-1:0] dout_b;
  logic          lvo_b, fvo_b, fdo_b, werr_b;
  logic [3:0]    xs_b, ys_b;

  assign fv_b = fv & sat_en;

  dynamic_crop #(.DATA_WIDTH(10), .CHANNELS(3), .COORD_WIDTH(11)) dut (
    .clock_in(clk), .reset_in(rst), .data_in(data), .line_valid_in(lv), .frame_valid_in(fv),
    .x_start_in(x_start), .x_end_in(x_end), .y_start_in(y_start), .y_end_in(y_end),
    .decimation_in(dec), .data_out(dout), .line_valid_out(lvo), .frame_valid_out(fvo),
    .x_size_out(xs), .y_size_out(ys), .frame_done_out(fdo), .window_error_out(werr)
  );

  dynamic_crop #(.DATA_WIDTH(10), .CHANNELS(3), .COORD_WIDTH(4)) dut_sat (
    .clock_in(clk), .reset_in(rst), .data_in(data), .line_valid_in(lv), .frame_valid_in(fv_b),
    .x_start_in(x_start_b), .x_end_in(x_end_b), .y_start_in(y_start_b), .y_end_in(y_end_b),
    .decimation_in(2'd0), .data_out(dout_b), .line_valid_out(lvo_b), .frame_valid_out(fvo_b),
    .x_size_out(xs_b), .y_size_out(ys_b), .frame_done_out(fdo_b), .window_error_out(werr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int seen_a = 0, seen_b = 0, done_a = 0, done_b = 0;
  logic [PW-1:0] q_a[$], q_b[$];
  int dxs_a[$], dys_a[$], dxs_b[$], dys_b[$];
  int m_x0, m_x1, m_y0, m_y1, m_d;
  int chg_x0, chg_x1;
  logic fvo_prev = 1'b0, fvo_b_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every kept pixel and every done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    logic [PW-1:0] e;
    if (lvo) begin
      seen_a++;
      if (q_a.size() == 0) check("unexpected_pixel", {34'd0, dout}, 64'hdead);
      else begin e = q_a.pop_front(); check("pixel", {34'd0, dout}, {34'd0, e}); end
    end else check("idle_data", {34'd0, dout}, 64'd0);
    if (fdo) begin
      done_a++;
      check("done_edge", {62'd0, fvo_prev, fvo}, 64'd2);
      if (dxs_a.size() == 0) check("unexpected_done", 64'd1, 64'd0);
      else begin
        check("done_x_size", {53'd0, xs}, 64'(dxs_a.pop_front()));
        check("done_y_size", {53'd0, ys}, 64'(dys_a.pop_front()));
      end
    end
    if (lvo_b) begin
      seen_b++;
      if (q_b.size() == 0) check("b_unexpected_pixel", {34'd0, dout_b}, 64'hdead);
      else begin e = q_b.pop_front(); check("b_pixel", {34'd0, dout_b}, {34'd0, e}); end
    end
    if (fdo_b) begin
      done_b++;
      check("b_done_edge", {62'd0, fvo_b_prev, fvo_b}, 64'd2);
      if (dxs_b.size() == 0) check("b_unexpected_done", 64'd1, 64'd0);
      else begin
        check("b_done_x_size", {60'd0, xs_b}, 64'(dxs_b.pop_front()));
        check("b_done_y_size", {60'd0, ys_b}, 64'(dys_b.pop_front()));
      end
    end
    fvo_prev   = fvo;
    fvo_b_prev = fvo_b;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pix(input int fid, input int x, input int y);
    return {10'(fid), 10'(y), 10'(x)};
  endfunction

  task automatic set_window(input int x0, input int x1, input int y0, input int y1, input int d);
    m_x0 = x0; m_x1 = x1; m_y0 = y0; m_y1 = y1; m_d = d;
    x_start = 11'(x0); x_end = 11'(x1); y_start = 11'(y0); y_end = 11'(y1); dec = 2'(d);
  endtask

  task automatic drive_frame(input int w, input int h, input int fid, input int chg_line,
                             input int rst_line, input int exp_pix, input int exp_done,
                             input int exp_xs, input int exp_ys);
    int  x0 = m_x0, x1 = m_x1, y0 = m_y0, y1 = m_y1, stride = 1 << m_d;
    int  sa = seen_a, da = done_a, sb = seen_b, db = done_b;
    bit  ok = (x1 > x0) && (y1 > y0);
    bit  dropped = 1'b0;
    if (ok && exp_done != 0) begin
      dxs_a.push_back(exp_xs); dys_a.push_back(exp_ys);
      if (sat_en) begin dxs_b.push_back(exp_xs); dys_b.push_back(exp_ys); end
    end
    step(); fv = 1'b1; lv = 1'b0; rst = 1'b0;
    step();
    @(negedge clk);
    check("fv_rise", {63'd0, fvo}, {63'd0, ok});
    check("win_err", {63'd0, werr}, {63'd0, !ok});
    if (ok) begin
      check("x_size", {53'd0, xs}, 64'(exp_xs));
      check("y_size", {53'd0, ys}, 64'(exp_ys));
    end
    if (sat_en) begin
      check("b_fv_rise", {63'd0, fvo_b}, 64'd1);
      check("b_x_size", {60'd0, xs_b}, 64'(exp_xs));
    end
    for (int y = 0; y < h; y++) begin
      if (y == chg_line) begin x_start = 11'(chg_x0); x_end = 11'(chg_x1); end
      for (int x = 0; x < w; x++) begin
        step(); lv = 1'b1; data = pix(fid, x, y);
        rst = (y == rst_line) && (x == 0);
        if (rst) dropped = 1'b1;
        if (!dropped && ok && x >= x0 && x < x1 && y >= y0 && y < y1 &&
            ((x - x0) % stride) == 0 && ((y - y0) % stride) == 0) begin
          q_a.push_back(data);
          if (sat_en) q_b.push_back(data);
        end
        if (y == rst_line && x == 1) begin
          @(negedge clk);
          check("post_reset", {7'd0, lvo, fvo, fdo, werr, xs, ys, dout}, 64'd0);
        end
      end
      step(); lv = 1'b0; rst = 1'b0; data = '0;
      repeat (2) step();
    end
    step(); fv = 1'b0;
    repeat (4) step();
    @(negedge clk);
    check("pixel_count", 64'(seen_a - sa), 64'(exp_pix));
    check("done_count", 64'(done_a - da), 64'(exp_done));
    if (sat_en) begin
      check("b_pixel_count", 64'(seen_b - sb), 64'(exp_pix));
      check("b_done_count", 64'(done_b - db), 64'(exp_done));
    end
  endtask

  initial begin
    rst = 1'b1; fv = 1'b0; lv = 1'b0; data = '0; sat_en = 1'b0;
    chg_x0 = 0; chg_x1 = 0;
    x_start_b = 4'd0; x_end_b = 4'd15; y_start_b = 4'd0; y_end_b = 4'd2;
    set_window(0, 0, 0, 0, 0);
    repeat (3) step();
    @(negedge clk);
    check("reset_state", {7'd0, lvo, fvo, fdo, werr, xs, ys, dout}, 64'd0);
    check("b_reset_state", {14'd0, lvo_b, fvo_b, fdo_b, werr_b, xs_b, ys_b, dout_b}, 64'd0);
    step(); rst = 1'b0;
    repeat (3) step();

    set_window(0, 15, 0, 12, 0);  drive_frame(16, 12, 1, -1, -1, 180, 1, 15, 12);
    set_window(4, 20, 2, 18, 1);  drive_frame(32, 32, 2, -1, -1, 64, 1, 8, 8);
    set_window(0, 16, 0, 4, 0); chg_x0 = 10; chg_x1 = 14;
    drive_frame(16, 4, 3, 1, -1, 64, 1, 16, 4);
    set_window(10, 14, 0, 4, 0);  drive_frame(16, 4, 4, -1, -1, 16, 1, 4, 4);
    set_window(5, 5, 0, 4, 0);    drive_frame(8, 4, 5, -1, -1, 0, 0, 0, 0);
    set_window(0, 8, 0, 4, 2);    drive_frame(8, 4, 6, -1, -1, 2, 1, 2, 1);
    set_window(0, 8, 0, 6, 0);    drive_frame(8, 6, 7, -1, 3, 24, 0, 8, 6);
    drive_frame(8, 6, 8, -1, -1, 48, 1, 8, 6);
    set_window(0, 17, 0, 9, 3);   drive_frame(20, 10, 9, -1, -1, 6, 1, 3, 2);
    sat_en = 1'b1;
    set_window(0, 15, 0, 2, 0);   drive_frame(20, 2, 10, -1, -1, 30, 1, 15, 2);
    sat_en = 1'b0;

    repeat (2) step();
    check("queues_drained", 64'(q_a.size() + q_b.size() + dxs_a.size() + dxs_b.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dynamic_crop.md
# dynamic_crop

Runtime-configurable crop window with power-of-two decimation for the camera pixel pipeline. It supersedes the fixed-coordinate crop stages used for pan and zoom. Window and decimation settings are latched once per frame, so host writes never tear an image. It also reports the output image size and a frame-done strobe to the JPEG encoder, and sits in the pixel clock domain between debayer/metering and the encoder.

## Interface
Parameters:
- DATA_WIDTH, 10, bits per colour channel
- CHANNELS, 3, channels per pixel (1 for raw Bayer, 3 for RGB)
- COORD_WIDTH, 11, width of coordinates, counters and sizes

Ports:
- clock_in  in  1  pixel clock (36 MHz)
- reset_in  in  1  reset; one clock, reset is synchronous and active-high
- data_in  in  CHANNELS*DATA_WIDTH  packed pixel, channel 0 in LSBs
- line_valid_in  in  1  line valid, one pixel per cycle while high
- frame_valid_in  in  1  frame valid
- x_start_in, x_end_in, y_start_in, y_end_in  in  COORD_WIDTH each  window bounds, start inclusive, end exclusive
- decimation_in  in  2  keep 1 of 2^d pixels per axis (0 = 1:1, 1 = 1:2, 2 = 1:4, 3 = 1:8)
- data_out  out  CHANNELS*DATA_WIDTH  kept pixel, zero when line_valid_out is low
- line_valid_out  out  1  per-pixel strobe for kept pixels
- frame_valid_out  out  1  output frame valid
- x_size_out, y_size_out  out  COORD_WIDTH each  output image dimensions for the current frame
- frame_done_out  out  1  one-cycle pulse at the end of a good frame
- window_error_out  out  1  the latched window is empty; the frame is suppressed

## Operation
- State machine:
  - WAIT_IDLE, entered at reset: waits for frame_valid_in = 0, then goes to ARMED.
  - ARMED: on a frame_valid_in rising edge, latches all window and decimation inputs into shadow registers.
    - Goes to SKIP if x_end <= x_start or y_end <= y_start.
    - Otherwise goes to ACTIVE.
  - ACTIVE, on frame_valid_in falling edge: pulses frame_done_out and goes to ARMED.
  - SKIP, on frame_valid_in falling edge: goes to ARMED with no pulse.
- Inputs are ignored outside the latch cycle. Mid-frame changes take effect on the next frame.
- x counter:
  - Increments on each line_valid_in cycle.
  - Clears when line_valid_in is low.
  - Saturates at 2^COORD_WIDTH-1; no wrap.
- y counter:
  - Increments on each line_valid_in falling edge.
  - Clears when frame_valid_in is low.
  - Saturates the same way.
- Keep condition, all true: state ACTIVE, line_valid_in, x_start <= x < x_end, y_start <= y < y_end, low d bits of (x - x_start) zero, low d bits of (y - y_start) zero.
- Sizes: x_size = (x_end - x_start + 2^d - 1) >> d, computed in COORD_WIDTH+1 bits. y_size likewise. Both are registered at the latch cycle and held until the next latch.
- window_error_out is set at a latch into SKIP and cleared at the next latch into ACTIVE.
- line_valid_in while frame_valid_in is low is ignored.
- A rising edge of frame_valid_in together with line_valid_in high makes that pixel x = 0, y = 0.

## Timing
- All outputs are registered, with 1-cycle latency from the inputs.
- frame_valid_out rises 1 cycle after the latching edge, in ACTIVE only, and falls 1 cycle after frame_valid_in falls.
- frame_done_out is high in the same cycle frame_valid_out falls.
- x_size_out and y_size_out are valid from the cycle frame_valid_out rises.
- Reset values: all outputs 0, shadows 0, counters 0, state WAIT_IDLE.
- Reset asserted mid-frame: outputs are 0 the next cycle. The remainder of that frame is dropped, because WAIT_IDLE requires frame_valid_in low before re-arming.

## Structure
- camera_pkg holds shared items:
  - decimation typedef (DECIMATE_1/2/4/8);
  - state enum;
  - a size helper function reused by the encoder setup.
- Sub-module crop_position_counter: x/y counters with saturation and edge detection, parametrised by COORD_WIDTH.

## Test plan
- 16x12 frame, window x 0..15 / y 0..12, d = 0 -> 15x12 kept pixels; data_out equals data_in delayed 1 cycle; x_size = 15, y_size = 12; frame_done pulses once.
- 32x32 ramp, window x 4..20 / y 2..18, d = 1 -> 8x8 pixels, first kept pixel is (4,2) and every second column/row after it; x_size = y_size = 8.
- Window changed to x 10..14 mid-frame -> current frame unaffected; next frame yields 4-pixel lines.
- x_end = x_start = 5 -> window_error_out = 1, frame_valid_out stays 0, no frame_done; the next valid window clears the error.
- reset_in asserted at line 3 of frame 1 -> outputs 0 next cycle; rest of frame 1 dropped; frame 2 cropped normally.
- COORD_WIDTH = 4, 20-pixel line, window 0..15 -> counter saturates at 15 with no wrap; 15 pixels kept.
